// File: rtl/mc_control.sv
// mc_control - multicycle control unit for the RV32I core.
//
// Sequences each instruction through only the states its opcode needs. It
// waits on a ready/request memory handshake and traps on illegal opcodes or
// on a memory wait longer than MEM_TIMEOUT cycles.
//
// Optional feature macro: MC_CONTROL_PERF_EN
//   Defined   : cycle_cnt / retired_cnt are live wrapping counters.
//   Undefined : both outputs are tied to 0 and no counter flops exist.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high; forces FETCH
//   instr[31:0]   in   IR contents, stable from DECODE until the next FETCH
//   mem_ready     in   memory completes the current request this cycle
//   trap_clear    in   leaves TRAP back to FETCH
//   current_state out  state code (see table below)
//   mem_req       out  memory request (FETCH, MEM_RD, MEM_WR)
//   mem_we        out  memory write (MEM_WR)
//   ir_write      out  load IR (FETCH & mem_ready)
//   pc_write      out  PC += 4 (FETCH & mem_ready)
//   reg_write     out  register-file write (MEM_WB, ALU_WB)
//   instr_done    out  one-cycle retire pulse
//   trap          out  high while in TRAP
//   trap_cause    out  01 illegal opcode, 10 memory timeout
//   cycle_cnt     out  cycles since reset
//   retired_cnt   out  retired instructions
//
// state   | code | meaning
// FETCH   | 0    | request instruction word, wait for mem_ready
// DECODE  | 1    | check opcode legality
// EXECUTE | 2    | ALU op / address calc; branches retire here
// MEM_RD  | 3    | load request, wait for mem_ready
// MEM_WR  | 4    | store request, retires when mem_ready
// MEM_WB  | 5    | load result to register file
// ALU_WB  | 6    | ALU result to register file
// TRAP    | 15   | halted until trap_clear

module mc_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              mem_ready,
  input  logic              trap_clear,
  output logic [3:0]        current_state,
  output logic              mem_req,
  output logic              mem_we,
  output logic              ir_write,
  output logic              pc_write,
  output logic              reg_write,
  output logic              instr_done,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] retired_cnt
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXECUTE = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WR  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_ALU_WB  = 4'd6,
    S_TRAP    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        cause_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [6:0]        opcode;
  logic              legal;
  logic              wait_state;
  logic              timeout;
  logic              instr_unused;

  assign opcode       = instr[6:0];
  assign instr_unused = ^instr[31:7];

  always_comb begin
    case (opcode)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end

  assign wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // The counter holds the number of stall cycles already spent. mem_ready in
  // the cycle the limit is reached still completes the access.
  assign timeout = (MEM_TIMEOUT != 0) && wait_state && !mem_ready && (wait_cnt == WAIT_LIMIT);

  always_comb begin
    state_nxt = state;
    cause_nxt = trap_cause;
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          state_nxt = S_DECODE;
        end else if (timeout) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_nxt = S_EXECUTE;
        end else begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end
      end
      S_EXECUTE: begin
        case (opcode)
          OP_LOAD:   state_nxt = S_MEM_RD;
          OP_STORE:  state_nxt = S_MEM_WR;
          OP_BRANCH: state_nxt = S_FETCH;
          default:   state_nxt = S_ALU_WB;
        endcase
      end
      S_MEM_RD: begin
        if (mem_ready) begin
          state_nxt = S_MEM_WB;
        end else if (timeout) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_nxt = S_FETCH;
        end else if (timeout) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WB: state_nxt = S_FETCH;
      S_ALU_WB: state_nxt = S_FETCH;
      S_TRAP: begin
        if (trap_clear) begin
          state_nxt = S_FETCH;
          cause_nxt = 2'b00;
        end
      end
      default: begin
        state_nxt = S_TRAP;
        cause_nxt = CAUSE_ILLEGAL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      trap_cause <= 2'b00;
      wait_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      trap_cause <= cause_nxt;
      // Any state change clears the counter, which covers every entry into
      // FETCH, MEM_RD and MEM_WR.
      if (state_nxt != state) begin
        wait_cnt <= '0;
      end else if ((MEM_TIMEOUT != 0) && wait_state && !mem_ready && (wait_cnt != WAIT_LIMIT)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  always_comb begin
    current_state = state;
    mem_req       = wait_state;
    mem_we        = (state == S_MEM_WR);
    // Gated by reset so a high mem_ready cannot strobe the IR/PC while held.
    ir_write      = (state == S_FETCH) && mem_ready && !reset;
    pc_write      = ir_write;
    reg_write     = (state == S_MEM_WB) || (state == S_ALU_WB);
    trap          = (state == S_TRAP);
    instr_done    = (state == S_ALU_WB) || (state == S_MEM_WB) ||
                    ((state == S_MEM_WR) && mem_ready) ||
                    ((state == S_EXECUTE) && (opcode == OP_BRANCH));
  end

`ifdef MC_CONTROL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + PERF_W'(1);
      if (instr_done) begin
        retired_cnt <= retired_cnt + PERF_W'(1);
      end
    end
  end
`else
  assign cycle_cnt   = '0;
  assign retired_cnt = '0;
`endif

endmodule

// File: doc/mc_control.md
# mc_control

Parametrised multicycle control unit for the RV32I core: the successor to the fixed FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer. It adds four things:
- opcode-dependent paths, so instructions only visit the states they need;
- a ready/request memory handshake with stall;
- a bounded memory-wait timeout;
- a trap state for illegal opcodes and timeouts.

It drives datapath strobes from `current_state` and sits between the instruction register, the memory port and the register file.

## Interface
- `MEM_TIMEOUT`, default 15: maximum stall cycles waiting on `mem_ready`; 0 disables the timeout.
- `PERF_W`, default 32: width of the performance counters.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; forces the FETCH state.
- `instr` input 32: IR contents; stable from DECODE until the next FETCH.
- `mem_ready` input 1: memory completes the current request this cycle.
- `trap_clear` input 1: in TRAP, returns the FSM to FETCH.
- `current_state` output 4: state encoding (see Operation).
- `mem_req` output 1: memory request.
- `mem_we` output 1: memory write.
- `ir_write` output 1: load the IR.
- `pc_write` output 1: PC += 4 at fetch.
- `reg_write` output 1: register-file write.
- `instr_done` output 1: one-cycle retire pulse.
- `trap` output 1: high while in TRAP.
- `trap_cause` output 2: registered cause; 01 = illegal opcode, 10 = memory timeout.
- `cycle_cnt` output PERF_W: cycles since reset.
- `retired_cnt` output PERF_W: retired instructions.

## Operation

State encoding:

| State | Code |
|---|---|
| FETCH | 0 |
| DECODE | 1 |
| EXECUTE | 2 |
| MEM_RD | 3 |
| MEM_WR | 4 |
| MEM_WB | 5 |
| ALU_WB | 6 |
| TRAP | 15 |

Unused codes go to TRAP with cause 01.

Transitions (opcode = `instr[6:0]`):
- FETCH → DECODE when `mem_ready`; otherwise stay.
- DECODE, legal opcode → EXECUTE. Legal opcodes: 0000011, 0100011, 0110011, 0010011, 1100011, 1101111, 1100111, 0110111, 0010111.
- DECODE, any other opcode → TRAP, with `trap_cause` = 01.
- EXECUTE, load (0000011) → MEM_RD.
- EXECUTE, store (0100011) → MEM_WR.
- EXECUTE, branch (1100011) → FETCH.
- EXECUTE, all other legal opcodes → ALU_WB.
- MEM_RD → MEM_WB when `mem_ready`.
- MEM_WR → FETCH when `mem_ready`.
- MEM_WB → FETCH.
- ALU_WB → FETCH.
- TRAP → FETCH when `trap_clear`; otherwise hold.

Outputs, decoded combinationally from state:
- `mem_req` = FETCH | MEM_RD | MEM_WR.
- `mem_we` = MEM_WR.
- `ir_write` = `pc_write` = FETCH & `mem_ready`.
- `reg_write` = MEM_WB | ALU_WB.
- `trap` = TRAP.
- `instr_done` = ALU_WB | MEM_WB | (MEM_WR & `mem_ready`) | (EXECUTE & branch).

Memory-wait timeout:
- The wait counter clears on entry to FETCH, MEM_RD or MEM_WR.
- It increments each cycle spent in one of these states with `mem_ready` low.
- When the count equals `MEM_TIMEOUT` (nonzero) and `mem_ready` is still low, the FSM goes to TRAP with `trap_cause` = 10.
- If `mem_ready` is high in that same cycle, `mem_ready` wins and no trap is taken.

`trap_cause`:
- Holds its value until the TRAP → FETCH exit, when it clears to 0.
- `trap_clear` outside TRAP is ignored.

Reset:
- Reset, including mid-instruction, clears state to FETCH, `trap_cause`, the wait counter and both perf counters, regardless of the cycle.
- `mem_req` reads 1 during reset, since the FSM sits in FETCH.
- All other outputs read 0 during reset.

## Timing

Instruction latency with `mem_ready` tied high:
- Branch: 3 cycles.
- R-type, I-type, lui, auipc, jal, jalr: 4 cycles.
- Store: 4 cycles.
- Load: 5 cycles.

Stall behaviour:
- Each low-`mem_ready` cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Requests are held (`mem_req`, `mem_we` stable) until `mem_ready` is seen.

Other timing:
- `instr_done` is a single-cycle pulse, in the final cycle before FETCH.
- The state register, `trap_cause` and the counters update on the rising `clk` edge.

## Configuration

`MC_CONTROL_PERF_EN`:
- Defined: `cycle_cnt` increments every cycle after reset, and `retired_cnt` increments on each `instr_done`. Both wrap modulo 2^PERF_W.
- Undefined: both outputs are tied to 0 and no counter flops exist.
- The FSM behaves identically either way.

## Test plan
- Reset, then `instr` = 32'h00023003 (lw) with `mem_ready` = 1: states 0,1,2,3,5,0; `reg_write` high in state 5; `instr_done` pulses once.
- `instr` = 32'h00c2a023 (sw) with `mem_ready` low for 3 cycles in MEM_WR: state 4 held 4 cycles with `mem_req` = `mem_we` = 1; `instr_done` is high in the cycle `mem_ready` rises; FETCH follows; no `reg_write`.
- `instr` = 32'h0000007f (illegal opcode): DECODE → TRAP (15), `trap` = 1, `trap_cause` = 01. Pulse `trap_clear` → FETCH with `trap_cause` = 0.
- `mem_ready` held low in FETCH with `MEM_TIMEOUT` = 15: TRAP is entered after 15 stall cycles with `trap_cause` = 10. Separately, raising `mem_ready` on exactly the 15th stall cycle gives DECODE and no trap.
- Assert `reset` asynchronously in EXECUTE of a branch (32'h00000063): state reads 0 immediately, before the next edge; counters read 0.
- With `MC_CONTROL_PERF_EN` defined, run 3 add instructions (32'h00000033) back-to-back: `retired_cnt` = 3 and `cycle_cnt` = 12. Rebuild without the macro: both outputs read 0.
